// File: rtl/yt3817_digit_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : yt3817_digit_pattern_gen
// Brief    : Synthetic raster source drawing one seven-segment digit inside
//            the central detection box. Feeds H_Addr/V_Addr/bin_data of the
//            binary picture processing unit in place of camera + binarizer.
// Ports    : clk, rst (sync, active-high)
//            frame_en                     - run request
//            digit_in/digit_valid/digit_ready - digit load handshake
//            H_Addr, V_Addr               - current raster position
//            de, bin_data                 - data enable / stroke pixel
//            frame_start, frame_done      - pulses on first / last pixel
//            cur_digit                    - digit drawn in this frame
// Revision : 1.0  initial release
// ============================================================================
module yt3817_digit_pattern_gen #(
    parameter int PIC_W   = 800,
    parameter int PIC_H   = 480,
    parameter int H_TOTAL = 1056,
    parameter int V_TOTAL = 525,
    parameter int X_MIN   = 336,
    parameter int X_MAX   = 464,
    parameter int Y_MIN   = 112,
    parameter int Y_MAX   = 368,
    parameter int SEG_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_en,
    input  logic [3:0]  digit_in,
    input  logic        digit_valid,
    output logic        digit_ready,
    output logic [11:0] H_Addr,
    output logic [11:0] V_Addr,
    output logic        de,
    output logic        bin_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic [3:0]  cur_digit
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [11:0] c_h_last  = 12'(H_TOTAL - 1);
    localparam logic [11:0] c_v_last  = 12'(V_TOTAL - 1);
    localparam logic [11:0] c_pic_w   = 12'(PIC_W);
    localparam logic [11:0] c_pic_h   = 12'(PIC_H);
    localparam logic [11:0] c_x_min   = 12'(X_MIN);
    localparam logic [11:0] c_x_max   = 12'(X_MAX);
    localparam logic [11:0] c_y_min   = 12'(Y_MIN);
    localparam logic [11:0] c_y_max   = 12'(Y_MAX);
    localparam logic [11:0] c_y_mid   = 12'((Y_MIN + Y_MAX) / 2);
    localparam logic [11:0] c_l_end   = 12'(X_MIN + SEG_W);
    localparam logic [11:0] c_r_beg   = 12'(X_MAX - SEG_W);
    localparam logic [11:0] c_a_end   = 12'(Y_MIN + SEG_W);
    localparam logic [11:0] c_d_beg   = 12'(Y_MAX - SEG_W);
    localparam logic [11:0] c_g_beg   = 12'((Y_MIN + Y_MAX) / 2 - SEG_W / 2);
    localparam logic [11:0] c_g_end   = 12'((Y_MIN + Y_MAX) / 2 + SEG_W / 2);

    // Lit segments per digit, bit order {a,b,c,d,e,f,g}; 10..15 are blank.
    function automatic logic [6:0] seg_mask(input logic [3:0] d);
        case (d)
            4'd0:    seg_mask = 7'b1111110;
            4'd1:    seg_mask = 7'b0110000;
            4'd2:    seg_mask = 7'b1101101;
            4'd3:    seg_mask = 7'b1111001;
            4'd4:    seg_mask = 7'b0110011;
            4'd5:    seg_mask = 7'b1011011;
            4'd6:    seg_mask = 7'b1011111;
            4'd7:    seg_mask = 7'b1110000;
            4'd8:    seg_mask = 7'b1111111;
            4'd9:    seg_mask = 7'b1111011;
            default: seg_mask = 7'b0000000;
        endcase
    endfunction

    logic [1:0]  r_state;
    logic [11:0] r_h, r_v;
    logic        r_de, r_bin, r_fs, r_fd;
    logic [3:0]  r_cur, r_pend;
    logic        r_pend_full;

    logic [1:0]  w_state_nxt;
    logic [11:0] w_h_nxt, w_v_nxt;
    logic        w_active;
    logic        w_last;
    logic        w_accept;
    logic        w_promote;
    logic        w_de_nxt, w_bin_nxt, w_fd_nxt;
    logic [3:0]  w_cur_nxt;
    logic        w_in_box;
    logic        w_upper, w_left, w_right;
    logic [6:0]  w_hit;

    assign w_last   = (r_h == c_h_last) && (r_v == c_v_last);
    // Ready is forced low while reset is held so nothing can be accepted.
    assign w_accept = digit_valid & digit_ready;

    // Next-state and next raster position.
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = 12'd0;
        w_v_nxt     = 12'd0;
        w_active    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_en) begin
                    w_state_nxt = S_RUN;
                    w_active    = 1'b1;
                end
            end
            S_RUN, S_DRAIN: begin
                w_active = 1'b1;
                if (r_h == c_h_last) begin
                    w_h_nxt = 12'd0;
                    w_v_nxt = (r_v == c_v_last) ? 12'd0 : r_v + 12'd1;
                end else begin
                    w_h_nxt = r_h + 12'd1;
                    w_v_nxt = r_v;
                end
                if (r_state == S_RUN) begin
                    if (!frame_en) w_state_nxt = S_DRAIN;
                end else if (frame_en) begin
                    w_state_nxt = S_RUN;
                end else if (w_last) begin
                    // Frame finished while draining: park at (0,0), inactive.
                    w_state_nxt = S_IDLE;
                    w_active    = 1'b0;
                    w_h_nxt     = 12'd0;
                    w_v_nxt     = 12'd0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pixel outputs are derived from the next position so they line up with
    // the registered address presented in the same cycle.
    always_comb begin
        w_promote = w_active && (w_h_nxt == 12'd0) && (w_v_nxt == 12'd0);
        w_cur_nxt = (w_promote && r_pend_full) ? r_pend : r_cur;
        w_de_nxt  = w_active && (w_h_nxt < c_pic_w) && (w_v_nxt < c_pic_h);
        w_fd_nxt  = w_active && (w_h_nxt == c_h_last) && (w_v_nxt == c_v_last);
        w_in_box  = (w_h_nxt >= c_x_min) && (w_h_nxt < c_x_max) &&
                    (w_v_nxt >= c_y_min) && (w_v_nxt < c_y_max);
        w_upper   = w_v_nxt < c_y_mid;
        w_left    = w_h_nxt < c_l_end;
        w_right   = w_h_nxt >= c_r_beg;
        w_hit     = {w_v_nxt < c_a_end,
                     w_right & w_upper,
                     w_right & ~w_upper,
                     w_v_nxt >= c_d_beg,
                     w_left & ~w_upper,
                     w_left & w_upper,
                     (w_v_nxt >= c_g_beg) && (w_v_nxt < c_g_end)};
        w_bin_nxt = w_de_nxt && w_in_box && (|(w_hit & seg_mask(w_cur_nxt)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_h         <= 12'd0;
            r_v         <= 12'd0;
            r_de        <= 1'b0;
            r_bin       <= 1'b0;
            r_fs        <= 1'b0;
            r_fd        <= 1'b0;
            r_cur       <= 4'hF;
            r_pend      <= 4'h0;
            r_pend_full <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
            r_de    <= w_de_nxt;
            r_bin   <= w_bin_nxt;
            r_fs    <= w_promote;
            r_fd    <= w_fd_nxt;
            r_cur   <= w_cur_nxt;
            // Accept needs an empty slot and promotion needs a full one, so
            // a digit taken on a boundary cycle stays pending for the next.
            if (w_accept) begin
                r_pend      <= digit_in;
                r_pend_full <= 1'b1;
            end else if (w_promote) begin
                r_pend_full <= 1'b0;
            end
        end
    end

    assign digit_ready = ~r_pend_full & ~rst;
    assign H_Addr      = r_h;
    assign V_Addr      = r_v;
    assign de          = r_de;
    assign bin_data    = r_bin;
    assign frame_start = r_fs;
    assign frame_done  = r_fd;
    assign cur_digit   = r_cur;

endmodule
`default_nettype wire

// File: tb/tb_yt3817_digit_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_yt3817_digit_pattern_gen
// Brief    : Directed self-checking bench for yt3817_digit_pattern_gen, using
//            a reduced raster geometry so whole frames stay short.
//            Geometry: 40x32 active, 48x36 total, box [12,28)x[4,28),
//            stroke 4, mid row 16 (g rows 14..17).
// Revision : 1.0  initial release
// ============================================================================
module tb_yt3817_digit_pattern_gen;

    localparam int PW = 40, PH = 32, HT = 48, VT = 36;
    localparam int XMN = 12, XMX = 28, YMN = 4, YMX = 28, SW = 4;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_en;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        digit_ready;
    logic [11:0] H_Addr, V_Addr;
    logic        de, bin_data, frame_start, frame_done;
    logic [3:0]  cur_digit;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_bad    = 0;
    int unsigned cyc      = 0;
    int unsigned t0, t1;
    int          sum;

    yt3817_digit_pattern_gen #(
        .PIC_W(PW), .PIC_H(PH), .H_TOTAL(HT), .V_TOTAL(VT),
        .X_MIN(XMN), .X_MAX(XMX), .Y_MIN(YMN), .Y_MAX(YMX), .SEG_W(SW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .frame_en    (frame_en),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .H_Addr      (H_Addr),
        .V_Addr      (V_Addr),
        .de          (de),
        .bin_data    (bin_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .cur_digit   (cur_digit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Continuous invariants: no stroke outside de, pulses only at their pixels.
    always @(negedge clk) begin
        if (!rst) begin
            if (!de && bin_data) n_bad++;
            if (frame_done && !(H_Addr == 12'(HT - 1) && V_Addr == 12'(VT - 1))) n_bad++;
            if (frame_start && (H_Addr != 12'd0 || V_Addr != 12'd0)) n_bad++;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pixel(input int h, input int v);
        int found;
        found = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (int'(H_Addr) == h && int'(V_Addr) == v) begin
                found = 1;
                break;
            end
            tick();
        end
        check_eq($sformatf("reach_%0d_%0d", h, v), found, 1);
    endtask

    task automatic pix(input int h, input int v, input int exp_bin, input string tag);
        wait_pixel(h, v);
        check_eq(tag, int'(bin_data), exp_bin);
    endtask

    task automatic offer(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_h"},   int'(H_Addr), 0);
        check_eq({tag, "_v"},   int'(V_Addr), 0);
        check_eq({tag, "_de"},  int'(de), 0);
        check_eq({tag, "_bin"}, int'(bin_data), 0);
        check_eq({tag, "_fs"},  int'(frame_start), 0);
        check_eq({tag, "_fd"},  int'(frame_done), 0);
        check_eq({tag, "_cur"}, int'(cur_digit), 15);
        check_eq({tag, "_rdy"}, int'(digit_ready), 0);
    endtask

    initial begin
        rst = 1'b1; frame_en = 1'b0; digit_valid = 1'b0; digit_in = 4'd0;
        tick(); tick(); tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();
        check_eq("post_rst_rdy", int'(digit_ready), 1);
        check_eq("post_rst_cur", int'(cur_digit), 15);

        // Frame 1: digit 8 loaded in IDLE.
        offer(4'd8);
        check_eq("load_rdy_low", int'(digit_ready), 0);
        check_eq("idle_h", int'(H_Addr), 0);
        frame_en = 1'b1;
        tick();
        t0 = cyc;
        check_eq("start_fs", int'(frame_start), 1);
        check_eq("start_h", int'(H_Addr), 0);
        check_eq("start_v", int'(V_Addr), 0);
        check_eq("start_cur8", int'(cur_digit), 8);
        check_eq("start_de", int'(de), 1);
        check_eq("start_rdy", int'(digit_ready), 1);
        pix(20, 5, 1, "d8_a");
        wait_pixel(40, 5);
        check_eq("de_hblank", int'(de), 0);
        offer(4'd1);
        pix(13, 10, 1, "d8_f");
        pix(20, 10, 0, "d8_hole");
        pix(20, 16, 1, "d8_g");
        pix(26, 20, 1, "d8_c");
        check_eq("cur_hold8", int'(cur_digit), 8);
        wait_pixel(0, 32);
        check_eq("de_vblank", int'(de), 0);
        wait_pixel(HT - 1, VT - 1);
        check_eq("f1_done", int'(frame_done), 1);
        check_eq("f1_done_cur", int'(cur_digit), 8);
        tick();
        t1 = cyc;
        check_eq("f2_fs", int'(frame_start), 1);
        check_eq("f2_cur1", int'(cur_digit), 1);
        check_eq("period", int'(t1 - t0), FRAME);

        // Frame 2: digit 1.
        pix(20, 5, 0, "d1_a");
        offer(4'd0);
        pix(13, 10, 0, "d1_f");
        pix(26, 10, 1, "d1_b");
        pix(20, 16, 0, "d1_g");
        pix(26, 20, 1, "d1_c");
        wait_pixel(HT - 1, VT - 1);
        tick();
        check_eq("f3_cur0", int'(cur_digit), 0);

        // Frame 3: digit 0.
        offer(4'd3);
        pix(20, 16, 0, "d0_g");
        pix(13, 20, 1, "d0_e");
        wait_pixel(HT - 1, VT - 1);
        tick();
        check_eq("f4_cur3", int'(cur_digit), 3);

        // Frame 4: digit 3, second offer while full is ignored.
        pix(13, 10, 0, "d3_f");
        pix(26, 10, 1, "d3_b");
        wait_pixel(0, 12);
        digit_in = 4'd7; digit_valid = 1'b1;
        tick();
        check_eq("offer7_rdy", int'(digit_ready), 0);
        digit_in = 4'd5;
        tick();
        digit_valid = 1'b0;
        check_eq("offer5_rdy", int'(digit_ready), 0);
        check_eq("hold3", int'(cur_digit), 3);
        wait_pixel(HT - 1, VT - 1);
        check_eq("f4_done", int'(frame_done), 1);
        check_eq("f4_done_cur", int'(cur_digit), 3);
        tick();
        check_eq("f5_fs", int'(frame_start), 1);
        check_eq("f5_cur7", int'(cur_digit), 7);
        check_eq("f5_rdy", int'(digit_ready), 1);

        // Frame 5: drop frame_en mid-frame, drain to IDLE.
        wait_pixel(10, 5);
        frame_en = 1'b0;
        tick();
        wait_pixel(HT - 1, VT - 1);
        check_eq("drain_done", int'(frame_done), 1);
        tick();
        check_eq("idle_h0", int'(H_Addr), 0);
        check_eq("idle_v0", int'(V_Addr), 0);
        check_eq("idle_fs", int'(frame_start), 0);
        check_eq("idle_de", int'(de), 0);
        repeat (5) tick();
        check_eq("idle_hold_h", int'(H_Addr), 0);
        check_eq("idle_hold_v", int'(V_Addr), 0);

        // Restart, then drop and re-assert inside DRAIN: no gap expected.
        frame_en = 1'b1;
        tick();
        check_eq("restart_fs", int'(frame_start), 1);
        check_eq("restart_cur", int'(cur_digit), 7);
        offer(4'd12);
        wait_pixel(5, 3);
        frame_en = 1'b0;
        tick(); tick();
        wait_pixel(10, 3);
        frame_en = 1'b1;
        wait_pixel(HT - 1, VT - 1);
        check_eq("redrain_done", int'(frame_done), 1);
        tick();
        check_eq("nogap_fs", int'(frame_start), 1);
        check_eq("nogap_h", int'(H_Addr), 0);
        check_eq("blank_cur", int'(cur_digit), 12);

        // Blank frame: no strokes anywhere.
        sum = 0;
        for (int i = 0; i < FRAME; i++) begin
            sum += int'(bin_data);
            if (i < FRAME - 1) tick();
        end
        check_eq("blank_frame", sum, 0);
        check_eq("blank_end_fd", int'(frame_done), 1);
        // Digit accepted on the boundary cycle is not promoted yet.
        offer(4'd8);
        check_eq("bnd_fs", int'(frame_start), 1);
        check_eq("bnd_cur", int'(cur_digit), 12);
        check_eq("bnd_rdy", int'(digit_ready), 0);
        wait_pixel(HT - 1, VT - 1);
        tick();
        check_eq("late_cur8", int'(cur_digit), 8);

        // Reset mid-frame discards the frame and the pending digit.
        pix(20, 5, 1, "d8b_a");
        offer(4'd9);
        check_eq("pend9_rdy", int'(digit_ready), 0);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        frame_en = 1'b0;
        rst = 1'b0;
        tick();
        check_eq("midrst_rdy", int'(digit_ready), 1);
        frame_en = 1'b1;
        tick();
        check_eq("lost_fs", int'(frame_start), 1);
        check_eq("lost_cur", int'(cur_digit), 15);

        check_eq("monitor", n_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
